sevenseg_scan_decoder: RTL

- Reads a multiplexed active-low seven-segment display bus (anodes plus CA..CG cathodes) and converts it back into hex nibbles. This is the read-back end of the team's hex-to-segment encoder.
- Used for loopback self-test of display drivers and for capturing the display contents of a second board.
- Digits are captured only after the bus has been stable for a programmable number of cycles, so scan transitions and ghosting are filtered out.
- Provides the per-digit values, per-digit valid and error flags, and a frame-complete pulse.

---
 rtl/sevenseg_scan_decoder.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/sevenseg_scan_decoder.sv
// Reads a multiplexed active-low seven-segment bus back into hex nibbles, capturing
// each digit once per dwell after a stability window. Optional SEVENSEG_ERR_CNT_EN adds err_cnt_o.
module sevenseg_scan_decoder #(
  parameter int DIGITS        = 4,
  parameter int STABLE_CYCLES = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [DIGITS-1:0]     an_i,
  input  logic [6:0]            ca_to_cg_i,
  input  logic                  clr_i,
  output logic [4*DIGITS-1:0]   value_o,
  output logic [DIGITS-1:0]     dig_valid_o,
  output logic [DIGITS-1:0]     err_o,
  output logic                  frame_done_o
`ifdef SEVENSEG_ERR_CNT_EN
  ,
  output logic [7:0]            err_cnt_o
`endif
);

  localparam int          IDX_W    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int          BUS_W    = DIGITS + 7;
  localparam logic [15:0] CNT_LAST = 16'(STABLE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, TRACK, CAPTURE, HOLD} state_e;

  // Returns {exactly_one_low, index_of_low_bit}.
  function automatic logic [IDX_W:0] find_low(input logic [DIGITS-1:0] an);
    logic [3:0]       n_low;
    logic [IDX_W-1:0] idx;
    n_low = '0;
    idx   = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (!an[i]) begin
        n_low = n_low + 4'd1;
        idx   = IDX_W'(i);
      end
    end
    return {(n_low == 4'd1), idx};
  endfunction

  // Returns {legal, nibble}; blank and unknown patterns come back as not legal.
  function automatic logic [4:0] decode(input logic [6:0] p);
    case (p)
      7'b0000001: decode = 5'h10;
      7'b1001111: decode = 5'h11;
      7'b0010010: decode = 5'h12;
      7'b0000110: decode = 5'h13;
      7'b1001100: decode = 5'h14;
      7'b0100100: decode = 5'h15;
      7'b0100000: decode = 5'h16;
      7'b0001111: decode = 5'h17;
      7'b0000000: decode = 5'h18;
      7'b0000100: decode = 5'h19;
      7'b0001000: decode = 5'h1A;
      7'b1100000: decode = 5'h1B;
      7'b0110001: decode = 5'h1C;
      7'b1000010: decode = 5'h1D;
      7'b0110000: decode = 5'h1E;
      7'b0111000: decode = 5'h1F;
      default:    decode = 5'h00;
    endcase
  endfunction

  logic [DIGITS-1:0]   an_s1_q, an_s2_q;
  logic [6:0]          seg_s1_q, seg_s2_q;
  logic [BUS_W-1:0]    prev_q;
  state_e              state_q, state_d;
  logic [15:0]         cnt_q, cnt_d;
  logic [4*DIGITS-1:0] value_q, value_d;
  logic [DIGITS-1:0]   valid_q, valid_d;
  logic [DIGITS-1:0]   err_q, err_d;
  logic [DIGITS-1:0]   mask_q, mask_d;
  logic                fd_q, fd_d;
`ifdef SEVENSEG_ERR_CNT_EN
  logic [7:0]          errcnt_q, errcnt_d;
`endif

  logic [IDX_W:0]   cur_low, cap_low;
  logic [IDX_W-1:0] cap_idx;
  logic [4:0]       glyph;
  logic             change, cur_ok, cap_blank;

  // The capture source is the previous sample, which TRACK has already proven stable.
  assign cur_low   = find_low(an_s2_q);
  assign cur_ok    = cur_low[IDX_W];
  assign cap_low   = find_low(prev_q[BUS_W-1:7]);
  assign cap_idx   = cap_low[IDX_W-1:0];
  assign glyph     = decode(prev_q[6:0]);
  assign cap_blank = (prev_q[6:0] == 7'h7F);
  assign change    = ({an_s2_q, seg_s2_q} != prev_q);

  // NOTE: every _d gets its default first, so no path through this block can infer a latch.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    value_d  = value_q;
    valid_d  = valid_q;
    err_d    = err_q;
    mask_d   = mask_q;
    fd_d     = 1'b0;
`ifdef SEVENSEG_ERR_CNT_EN
    errcnt_d = errcnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (cur_ok) begin
          cnt_d   = '0;
          state_d = TRACK;
        end
      end
      TRACK: begin
        if (change || !cur_ok) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 16'd1;
          if (cnt_d == CNT_LAST) state_d = CAPTURE;
        end
      end
      CAPTURE: begin
        if (glyph[4]) begin
          value_d[{cap_idx, 2'b00} +: 4] = glyph[3:0];
          valid_d[cap_idx] = 1'b1;
          err_d[cap_idx]   = 1'b0;
          mask_d[cap_idx]  = 1'b1;
          if (&mask_d) begin
            mask_d = '0;
            fd_d   = 1'b1;
          end
        end else if (!cap_blank) begin
          err_d[cap_idx] = 1'b1;
`ifdef SEVENSEG_ERR_CNT_EN
          if (errcnt_q != 8'hFF) errcnt_d = errcnt_q + 8'd1;
`endif
        end
        state_d = change ? IDLE : HOLD;
      end
      HOLD: begin
        if (change) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (clr_i) begin
      value_d  = '0;
      valid_d  = '0;
      err_d    = '0;
      mask_d   = '0;
      fd_d     = 1'b0;
      cnt_d    = '0;
      state_d  = IDLE;
`ifdef SEVENSEG_ERR_CNT_EN
      errcnt_d = '0;
`endif
    end
  end

  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      an_s1_q  <= '0;
      an_s2_q  <= '0;
      seg_s1_q <= '0;
      seg_s2_q <= '0;
      prev_q   <= '0;
      state_q  <= IDLE;
      cnt_q    <= '0;
      value_q  <= '0;
      valid_q  <= '0;
      err_q    <= '0;
      mask_q   <= '0;
      fd_q     <= 1'b0;
`ifdef SEVENSEG_ERR_CNT_EN
      errcnt_q <= '0;
`endif
    end else begin
      an_s1_q  <= an_i;
      an_s2_q  <= an_s1_q;
      seg_s1_q <= ca_to_cg_i;
      seg_s2_q <= seg_s1_q;
      prev_q   <= {an_s2_q, seg_s2_q};
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      value_q  <= value_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
      mask_q   <= mask_d;
      fd_q     <= fd_d;
`ifdef SEVENSEG_ERR_CNT_EN
      errcnt_q <= errcnt_d;
`endif
    end
  end

  assign value_o      = value_q;
  assign dig_valid_o  = valid_q;
  assign err_o        = err_q;
  assign frame_done_o = fd_q;
`ifdef SEVENSEG_ERR_CNT_EN
  assign err_cnt_o    = errcnt_q;
`endif

endmodule
